bht_update_ctrl: RTL and testbench
==================================

// Module: bht_update_ctrl
// PURPOSE
//  Owns the single write port of the 2-bit branch history table (BHT). Clears the table after reset,
//  buffers MEM-stage branch resolutions in a small FIFO and applies saturating-counter updates
//  via read-modify-write. Detects mispredictions and issues a registered flush/redirect to fetch.
//  Sits between the MEM stage, the BHT storage array and the IF-stage PC mux.
// PARAMETERS
//  IDX_W       11   BHT index width; table has 2**IDX_W entries, index = pc[IDX_W+1:2]
//  FIFO_DEPTH  4    update FIFO entries (power of two, >= 2)
//  INIT_STATE  2'b01 counter value written by the clear sweep (weakly not-taken)
// PORTS
//  clk                    in   1      rising-edge clock
//  reset                  in   1      synchronous, active-high
//  i_MEM_is_branch_instr  in   1      MEM holds a resolved conditional branch (one-cycle valid)
//  i_MEM_branch_pc        in   32     PC of that branch
//  i_MEM_is_take_branch   in   1      actual outcome
//  i_MEM_target_pc        in   32     actual taken target
//  i_MEM_pred_next_pc     in   32     next PC fetch used for this branch
//  o_bht_raddr            out  IDX_W  BHT read address (synchronous read, data next cycle)
//  i_bht_rdata            in   2      BHT read data
//  o_bht_we               out  1      BHT write enable
//  o_bht_waddr            out  IDX_W  BHT write address
//  o_bht_wdata            out  2      BHT write data
//  o_pred_enable          out  1      0 = predictor must predict not-taken (table not valid)
//  o_flush                out  1      one-cycle pulse: squash IF/ID/EX
//  o_redirect_pc          out  32     fetch target, valid while o_flush=1
//  o_upd_drop             out  1      one-cycle pulse: update discarded (FIFO full)
//  o_stat_branches        out  32     resolved-branch count (see CONFIGURATION)
//  o_stat_mispred         out  32     misprediction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=INIT, sweep idx=0, FIFO empty; o_flush=0, o_upd_drop=0, o_pred_enable=0, o_bht_we=0,
//   o_redirect_pc=0, stats=0. Reset mid-sweep or mid-update restarts INIT and discards the FIFO.
//  FSM INIT: o_bht_we=1, waddr=idx, wdata=INIT_STATE, idx++ each cycle. At idx=2**IDX_W-1 -> IDLE.
//   The sweep takes exactly 2**IDX_W cycles. o_pred_enable is registered and rises the cycle after the last write.
//  IDLE: FIFO non-empty -> RD. o_bht_raddr=head idx.
//  RD: raddr held at head idx; -> WR.
//  WR: wdata=sat(i_bht_rdata, head.taken), o_bht_we=1, FIFO pop. -> RD if another entry is present, else IDLE.
//   sat: taken 00->01->10->11 (11 holds); not-taken 11->10->01->00 (00 holds).
//   Throughput is one update per 2 cycles. The RD-then-WR order gives same-index entries correct sequencing.
//  Push: i_MEM_is_branch_instr && state!=INIT. Entry = {pc[IDX_W+1:2], taken}.
//   Branches resolved during INIT are not enqueued and not counted as drops.
//  Full: a push is accepted if a WR pop happens in the same cycle. Otherwise the push is discarded and
//   o_upd_drop pulses next cycle. The BHT is a hint, so the pipeline never stalls.
//  Mispredict: actual_next = taken ? i_MEM_target_pc : i_MEM_branch_pc+32'd4 (mod 2^32).
//   Mispredict = is_branch && actual_next != i_MEM_pred_next_pc.
//   It is detected in every state, including INIT.
//   Registered: o_flush=1 and o_redirect_pc=actual_next one cycle after the MEM valid cycle.
//   o_redirect_pc holds its value until the next flush.
//  Back-to-back mispredicts give consecutive flush pulses; the later redirect wins.
//  The flush does not touch the FIFO (resolved branches are architecturally real).
// CONFIGURATION
//  BHT_UPDATE_CTRL_STATS_EN defined:
//   o_stat_branches increments on every MEM branch, including during INIT.
//   o_stat_mispred increments on every mispredict.
//   Both are 32-bit wrap-around counters, cleared by reset.
//  BHT_UPDATE_CTRL_STATS_EN undefined: counters not built; both ports tied to 32'd0.
// STRUCTURE
//  Package bht_pkg holds:
//   state enum {INIT, IDLE, RD, WR};
//   counter encodings SNT=00, WNT=01, WT=10, ST=11;
//   the default IDX_W;
//   the FIFO entry struct {idx, taken}.
//  Sub-module bht_upd_fifo: parameterised sync FIFO (push/pop/full/empty, same-cycle push+pop on full).
//  The FSM, saturating logic, mispredict compare and stats stay in bht_update_ctrl.
// TESTING
//  1. Reset release, IDX_W=4:
//     16 writes idx 0..15, wdata=01; o_pred_enable=1 on cycle 17; no other writes.
//  2. Taken branch pc=0x40 with pred_next=0x44, target=0x100:
//     o_flush next cycle, redirect=0x100; RD/WR on idx 0x10 with rdata 01 -> wdata 10.
//  3. Four taken updates to the same idx from rdata 10:
//     writes 11,11,11,11 (saturation). Not-taken from 00 -> writes 00.
//  4. Branch every cycle for 12 cycles, FIFO_DEPTH=4:
//     no stall, o_upd_drop pulses once per discarded push, and count(writes)+drops=12.
//  5. Assert reset mid-sweep (idx=7) and again with 3 queued entries:
//     the sweep restarts at 0, the FIFO is empty, and no stale update write appears afterwards.
//  6. With STATS_EN, run 5 branches (2 mispredicted): stats 5/2.
//     Without STATS_EN: both stats read 0.
//     Correct predict, not-taken, pred_next=pc+4: no flush.

Source files
------------

// File: rtl/bht_pkg.sv
// ============================================================================
// Module  : bht_pkg
// Brief   : Shared types for the BHT update controller: FSM state encoding,
//           2-bit counter encodings, default index width, FIFO entry struct
//           and the saturating-counter step function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bht_pkg;

    // Controller states: table clear sweep, waiting, read, write-back
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } bht_state_e;

    // 2-bit saturating counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Default table index width (2**11 entries)
    localparam int BHT_IDX_W_DEF = 11;

    // Widest index a 32-bit word-aligned PC can supply (pc[31:2]); the entry
    // struct is sized for it so one type serves every IDX_W.
    localparam int BHT_IDX_W_MAX = 30;

    // One queued update: table index and resolved direction
    typedef struct packed {
        logic [BHT_IDX_W_MAX-1:0] idx;
        logic                     taken;
    } bht_entry_t;

    // Step a counter one position toward the resolved direction, saturating
    function automatic logic [1:0] bht_sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bht_update_ctrl_if.sv
// ============================================================================
// Module  : bht_update_ctrl_if
// Brief   : Bundles the MEM-stage resolution bus, the BHT read/write port,
//           the fetch flush/redirect and the status outputs of
//           bht_update_ctrl. The slave modport is the controller's view;
//           the master modport is the surrounding pipeline/storage view.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bht_update_ctrl_if #(
    parameter int IDX_W = bht_pkg::BHT_IDX_W_DEF
);
    // MEM-stage branch resolution
    logic             i_MEM_is_branch_instr;
    logic [31:0]      i_MEM_branch_pc;
    logic             i_MEM_is_take_branch;
    logic [31:0]      i_MEM_target_pc;
    logic [31:0]      i_MEM_pred_next_pc;
    // BHT storage port
    logic [IDX_W-1:0] o_bht_raddr;
    logic [1:0]       i_bht_rdata;
    logic             o_bht_we;
    logic [IDX_W-1:0] o_bht_waddr;
    logic [1:0]       o_bht_wdata;
    // Predictor / fetch control
    logic             o_pred_enable;
    logic             o_flush;
    logic [31:0]      o_redirect_pc;
    logic             o_upd_drop;
    // Statistics
    logic [31:0]      o_stat_branches;
    logic [31:0]      o_stat_mispred;

    modport master (
        output i_MEM_is_branch_instr, i_MEM_branch_pc, i_MEM_is_take_branch,
               i_MEM_target_pc, i_MEM_pred_next_pc, i_bht_rdata,
        input  o_bht_raddr, o_bht_we, o_bht_waddr, o_bht_wdata, o_pred_enable,
               o_flush, o_redirect_pc, o_upd_drop, o_stat_branches, o_stat_mispred
    );

    modport slave (
        input  i_MEM_is_branch_instr, i_MEM_branch_pc, i_MEM_is_take_branch,
               i_MEM_target_pc, i_MEM_pred_next_pc, i_bht_rdata,
        output o_bht_raddr, o_bht_we, o_bht_waddr, o_bht_wdata, o_pred_enable,
               o_flush, o_redirect_pc, o_upd_drop, o_stat_branches, o_stat_mispred
    );

endinterface

`default_nettype wire

// File: rtl/bht_upd_fifo.sv
// ============================================================================
// Module  : bht_upd_fifo
// Brief   : Synchronous FIFO of pending BHT updates. A push while full is
//           accepted only when a pop happens in the same cycle; otherwise it
//           is ignored (the caller reports the drop). Head is read
//           combinationally from the storage array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int DEPTH = 4   // power of two, >= 2
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     push_i,
    input  wire bht_entry_t               data_i,
    input  wire logic                     pop_i,
    output bht_entry_t                    data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    bht_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            w_wr_en;
    logic            w_rd_en;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // The freed slot makes a push-on-full legal when it coincides with a pop
    assign w_wr_en = push_i && (!full_o || pop_i);
    assign w_rd_en = pop_i && !empty_o;

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (w_rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bht_update_ctrl.sv
// ============================================================================
// Module  : bht_update_ctrl
// Brief   : Sole writer of the 2-bit branch history table. Clears the table
//           after reset, queues MEM-stage branch resolutions and applies
//           saturating-counter updates by read-modify-write (one per two
//           cycles). Detects mispredictions and issues a registered
//           flush/redirect to fetch.
//           Optional: define BHT_UPDATE_CTRL_STATS_EN to build the resolved
//           branch / misprediction counters (otherwise they read 0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_update_ctrl
    import bht_pkg::*;
#(
    parameter int         IDX_W      = BHT_IDX_W_DEF,  // table has 2**IDX_W entries
    parameter int         FIFO_DEPTH = 4,              // power of two, >= 2
    parameter logic [1:0] INIT_STATE = CTR_WNT         // value written by the clear sweep
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bht_update_ctrl_if.slave   bus
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    bht_state_e        state_q;
    logic [IDX_W-1:0]  sweep_idx_q;
    logic              pred_en_q;
    logic              flush_q;
    logic [31:0]       redirect_q;
    logic              drop_q;

    bht_entry_t        w_push_entry;
    bht_entry_t        w_head;
    logic [IDX_W-1:0]  w_head_idx;
    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_drop;
    logic [31:0]       w_actual_next;
    logic              w_mispredict;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [1:0]        w_wdata;

    // ------------------------------------------------------------------
    // Update queue
    // ------------------------------------------------------------------
    // Branches resolved during the clear sweep are neither queued nor drops
    assign w_push_req = bus.i_MEM_is_branch_instr && (state_q != S_INIT);
    assign w_pop      = (state_q == S_WR);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Build the queued entry from the branch PC word index and outcome
    always_comb begin
        w_push_entry                  = '0;
        w_push_entry.idx[IDX_W-1:0]   = bus.i_MEM_branch_pc[IDX_W+1:2];
        w_push_entry.taken            = bus.i_MEM_is_take_branch;
    end

    bht_upd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push_req),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_head_idx = w_head.idx[IDX_W-1:0];

    // Index bits above IDX_W are always zero in queued entries
    if (IDX_W < BHT_IDX_W_MAX) begin : g_idx_pad
        logic w_unused_idx_hi;
        assign w_unused_idx_hi = ^w_head.idx[BHT_IDX_W_MAX-1:IDX_W];
    end

    // ------------------------------------------------------------------
    // BHT port
    // ------------------------------------------------------------------
    // The read address follows the queue head, so the RD cycle re-reads it
    // after any write to the same index in the preceding WR cycle.
    assign bus.o_bht_raddr = w_head_idx;

    // Write port decode: sweep value in INIT, saturated counter in WR
    always_comb begin
        w_we    = 1'b0;
        w_waddr = sweep_idx_q;
        w_wdata = INIT_STATE;
        case (state_q)
            S_INIT: begin
                w_we = 1'b1;
            end
            S_WR: begin
                w_we    = 1'b1;
                w_waddr = w_head_idx;
                w_wdata = bht_sat_next(bus.i_bht_rdata, w_head.taken);
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // No table write may escape while reset is held
    assign bus.o_bht_we    = w_we && !reset;
    assign bus.o_bht_waddr = w_waddr;
    assign bus.o_bht_wdata = w_wdata;

    // Controller FSM: clear sweep, then read-modify-write per queued entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            sweep_idx_q <= '0;
            pred_en_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    sweep_idx_q <= sweep_idx_q + IDX_ONE;
                    if (sweep_idx_q == IDX_LAST) begin
                        state_q   <= S_IDLE;
                        pred_en_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!w_empty) begin
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_WR;
                end
                S_WR: begin
                    // Another entry remains if more than the popped one was
                    // queued, or a new one arrives together with the pop
                    if ((w_count > CNT_ONE) || w_push_req) begin
                        state_q <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign bus.o_pred_enable = pred_en_q;

    // ------------------------------------------------------------------
    // Misprediction detection and fetch redirect
    // ------------------------------------------------------------------
    assign w_actual_next = bus.i_MEM_is_take_branch ? bus.i_MEM_target_pc
                                                    : (bus.i_MEM_branch_pc + 32'd4);
    assign w_mispredict  = bus.i_MEM_is_branch_instr &&
                           (w_actual_next != bus.i_MEM_pred_next_pc);

    // Registered flush pulse, held redirect target and drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q    <= 1'b0;
            redirect_q <= 32'd0;
            drop_q     <= 1'b0;
        end else begin
            flush_q <= w_mispredict;
            drop_q  <= w_drop;
            if (w_mispredict) begin
                redirect_q <= w_actual_next;
            end
        end
    end

    assign bus.o_flush       = flush_q;
    assign bus.o_redirect_pc = redirect_q;
    assign bus.o_upd_drop    = drop_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BHT_UPDATE_CTRL_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    // Wrap-around event counters, active in every state including INIT
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            if (bus.i_MEM_is_branch_instr) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (w_mispredict) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign bus.o_stat_branches = stat_br_q;
    assign bus.o_stat_mispred  = stat_mis_q;
`else
    assign bus.o_stat_branches = 32'd0;
    assign bus.o_stat_mispred  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bht_update_ctrl.sv
// ============================================================================
// Module  : tb_bht_update_ctrl
// Brief   : Self-checking bench for bht_update_ctrl (IDX_W=4, FIFO_DEPTH=4).
//           Table vectors, hand sequences for multi-cycle corners and a
//           randomized run against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bht_update_ctrl;
    import bht_pkg::*;

    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int NENT  = 16;
    localparam int SWEEP = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bht_update_ctrl_if #(.IDX_W(IDX_W)) bus();

    bht_update_ctrl #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (DEPTH),
        .INIT_STATE (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read BHT storage (read returns pre-write contents)
    logic [1:0] mem [NENT];
    always @(posedge clk) begin
        if (bus.o_bht_we) mem[bus.o_bht_waddr] <= bus.o_bht_wdata;
        bus.i_bht_rdata <= mem[bus.o_bht_raddr];
    end

    // ---------------- reference model state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          k_since_rst = 0;
    bit          m_flush = 0;
    logic [31:0] m_redir = 0;
    bit          m_pred  = 0;
    int unsigned m_br = 0, m_mis = 0;
    bit          pend_push = 0;
    int          pend_idx = 0;
    bit          pend_tk = 0;
    int          exp_idx_q[$];
    bit          exp_tk_q[$];
    int          ref_tbl[NENT];
    int          n_push = 0, n_drop = 0, n_upd_wr = 0;
    int          last_waddr = -1, last_wdata = -1;

    function automatic int ref_sat(int c, bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model
    task automatic tick(input bit rst_v, input bit br, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input logic [31:0] pn);
        logic [31:0] act_next;
        bit mis;
        int cur;
        int ei, ew;
        bit et;
        reset = rst_v;
        bus.i_MEM_is_branch_instr = br;
        bus.i_MEM_branch_pc       = pc;
        bus.i_MEM_is_take_branch  = tk;
        bus.i_MEM_target_pc       = tgt;
        bus.i_MEM_pred_next_pc    = pn;
        cur = rst_v ? 0 : k_since_rst + 1;
        @(negedge clk);
        check("flush", bus.o_flush, m_flush);
        check("redirect", bus.o_redirect_pc, m_redir);
        check("pred_enable", bus.o_pred_enable, m_pred);
`ifdef BHT_UPDATE_CTRL_STATS_EN
        check("stat_branches", bus.o_stat_branches, m_br);
        check("stat_mispred", bus.o_stat_mispred, m_mis);
`else
        check("stat_branches", bus.o_stat_branches, 0);
        check("stat_mispred", bus.o_stat_mispred, 0);
`endif
        // drop pulse belongs to the previous cycle's push
        if (!pend_push) begin
            check("drop_without_push", bus.o_upd_drop, 0);
        end else if (bus.o_upd_drop) begin
            n_drop++;
        end else begin
            exp_idx_q.push_back(pend_idx);
            exp_tk_q.push_back(pend_tk);
        end
        // write port
        if (rst_v) begin
            check("we_in_reset", bus.o_bht_we, 0);
        end else if (cur <= SWEEP) begin
            check("sweep_we", bus.o_bht_we, 1);
            check("sweep_waddr", bus.o_bht_waddr, cur - 1);
            check("sweep_wdata", bus.o_bht_wdata, 1);
        end else if (bus.o_bht_we) begin
            n_upd_wr++;
            last_waddr = int'(bus.o_bht_waddr);
            last_wdata = int'(bus.o_bht_wdata);
            if (exp_idx_q.size() == 0) begin
                check("stale_update_write", 1, 0);
            end else begin
                ei = exp_idx_q.pop_front();
                et = exp_tk_q.pop_front();
                ew = ref_sat(ref_tbl[ei], et);
                ref_tbl[ei] = ew;
                check("upd_waddr", bus.o_bht_waddr, ei);
                check("upd_wdata", bus.o_bht_wdata, ew);
            end
        end
        // advance model with this cycle's inputs
        if (rst_v) begin
            m_flush = 0; m_redir = 0; m_br = 0; m_mis = 0; m_pred = 0;
            pend_push = 0; k_since_rst = 0;
            exp_idx_q.delete(); exp_tk_q.delete();
            for (int i = 0; i < NENT; i++) ref_tbl[i] = 1;
        end else begin
            act_next = tk ? tgt : pc + 32'd4;
            mis = br && (act_next != pn);
            m_flush = mis;
            if (mis) m_redir = act_next;
            if (br) m_br++;
            if (mis) m_mis++;
            pend_push = br && (cur > SWEEP);
            pend_idx  = int'((pc >> 2) % NENT);
            pend_tk   = tk;
            if (pend_push) n_push++;
            k_since_rst = cur;
            m_pred = (cur >= SWEEP);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 32'd0, 0, 32'd0, 32'd0);
    endtask

    task automatic branch(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                          input logic [31:0] pn);
        tick(0, 1, pc, tk, tgt, pn);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          tk;
        logic [31:0] tgt;
        logic [31:0] pn;
        bit          e_flush;
        logic [31:0] e_redir;
        int          e_waddr;
        int          e_wdata;
    } vec_t;

    vec_t vt[9];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0, d0, p0;
        logic [31:0] pc, tgt, pn, an;
        bit tk;

        // pc, taken, target, pred_next | flush, redirect, waddr, wdata
        vt[0] = '{32'h0000_0040, 1, 32'h0000_0100, 32'h0000_0044, 1, 32'h0000_0100, 0, 2};
        vt[1] = '{32'h0000_0040, 1, 32'h0000_0100, 32'h0000_0100, 0, 32'h0,       0, 3};
        vt[2] = '{32'h0000_0040, 1, 32'h0000_0100, 32'h0000_0100, 0, 32'h0,       0, 3};
        vt[3] = '{32'h0000_0044, 0, 32'h0000_0200, 32'h0000_0048, 0, 32'h0,       1, 0};
        vt[4] = '{32'h0000_0044, 0, 32'h0000_0200, 32'h0000_0200, 1, 32'h0000_0048, 1, 0};
        vt[5] = '{32'hFFFF_FFFC, 0, 32'h0000_0300, 32'h0000_0000, 0, 32'h0,       15, 0};
        vt[6] = '{32'hFFFF_FFFC, 0, 32'h0000_0300, 32'h0000_0004, 1, 32'h0000_0000, 15, 0};
        vt[7] = '{32'h0000_0080, 1, 32'h0000_0080, 32'h0000_0084, 1, 32'h0000_0080, 0, 3};
        vt[8] = '{32'h0000_0048, 1, 32'h0000_1000, 32'h0000_1000, 0, 32'h0,       2, 2};

        bus.i_MEM_is_branch_instr = 0;
        bus.i_MEM_branch_pc = 0;
        bus.i_MEM_is_take_branch = 0;
        bus.i_MEM_target_pc = 0;
        bus.i_MEM_pred_next_pc = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and clear sweep (per-cycle sweep checks in tick)
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        idle(20);
        for (int i = 0; i < NENT; i++) check($sformatf("table_after_sweep[%0d]", i), mem[i], 1);

        // Table-driven single updates
        for (int v = 0; v < 9; v++) begin
            w0 = n_upd_wr;
            branch(vt[v].pc, vt[v].tk, vt[v].tgt, vt[v].pn);
            check($sformatf("vec%0d_flush", v), bus.o_flush, vt[v].e_flush);
            if (vt[v].e_flush) check($sformatf("vec%0d_redirect", v), bus.o_redirect_pc, vt[v].e_redir);
            idle(5);
            check($sformatf("vec%0d_nwrites", v), n_upd_wr - w0, 1);
            check($sformatf("vec%0d_waddr", v), last_waddr, vt[v].e_waddr);
            check($sformatf("vec%0d_wdata", v), last_wdata, vt[v].e_wdata);
        end

        // Same-index back-to-back taken updates saturate at 11
        branch(32'h4C, 1, 32'h4C, 32'h4C);
        idle(5);
        w0 = n_upd_wr;
        for (int i = 0; i < 4; i++) branch(32'h4C, 1, 32'h4C, 32'h4C);
        idle(12);
        check("sat_nwrites", n_upd_wr - w0, 4);
        check("sat_last_wdata", last_wdata, 3);
        // Not-taken from 00 holds 00; correct prediction gives no flush
        branch(32'h44, 0, 32'h500, 32'h48);
        check("nt_correct_noflush", bus.o_flush, 0);
        idle(5);
        check("nt_hold_waddr", last_waddr, 1);
        check("nt_hold_wdata", last_wdata, 0);

        // Branch every cycle for 12 cycles into an empty queue
        w0 = n_upd_wr; d0 = n_drop; p0 = n_push;
        for (int i = 0; i < 12; i++) begin
            pc = 32'h0000_0200 + 32'(i * 4);
            branch(pc, i[0], 32'h800, i[0] ? 32'h800 : pc + 32'd4);
        end
        idle(20);
        check("burst_pushes", n_push - p0, 12);
        check("burst_drops", n_drop - d0, 3);
        check("burst_writes", n_upd_wr - w0, 9);
        check("burst_writes_plus_drops", (n_upd_wr - w0) + (n_drop - d0), 12);

        // Reset mid-sweep at idx 7, with a mispredict during INIT
        tick(1, 0, 0, 0, 0, 0);
        idle(8);
        tick(1, 0, 0, 0, 0, 0);
        idle(2);
        branch(32'h40, 1, 32'h300, 32'h44);
        check("init_flush", bus.o_flush, 1);
        check("init_redirect", bus.o_redirect_pc, 32'h300);
        idle(20);
        // Reset with three queued entries
        branch(32'h50, 1, 32'h0, 32'h0);
        branch(32'h54, 1, 32'h0, 32'h0);
        branch(32'h58, 1, 32'h0, 32'h0);
        w0 = n_upd_wr;
        tick(1, 0, 0, 0, 0, 0);
        idle(30);
        check("no_stale_writes", n_upd_wr - w0, 0);
        for (int i = 0; i < NENT; i++) check($sformatf("table_after_reset[%0d]", i), mem[i], 1);

        // Randomized traffic against the reference model
        w0 = n_upd_wr; d0 = n_drop; p0 = n_push;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 35) begin
                pc  = $urandom() & 32'hFFFF_FFFC;
                tk  = $urandom_range(0, 1);
                tgt = $urandom() & 32'hFFFF_FFFC;
                an  = tk ? tgt : pc + 32'd4;
                pn  = ($urandom_range(0, 9) < 3) ? ($urandom() & 32'hFFFF_FFFC) : an;
                branch(pc, tk, tgt, pn);
            end else begin
                idle(1);
            end
        end
        idle(30);
        check("rand_drained", exp_idx_q.size(), 0);
        check("rand_writes_plus_drops", (n_upd_wr - w0) + (n_drop - d0), n_push - p0);
        for (int i = 0; i < NENT; i++) check($sformatf("table_final[%0d]", i), mem[i], ref_tbl[i]);

        // Statistics: 5 branches (2 mispredicted) right after reset
        tick(1, 0, 0, 0, 0, 0);
        branch(32'h100, 1, 32'h200, 32'h104);
        branch(32'h104, 0, 32'h0,   32'h108);
        branch(32'h108, 0, 32'h0,   32'h300);
        branch(32'h10C, 1, 32'h400, 32'h400);
        branch(32'h110, 0, 32'h0,   32'h114);
        idle(1);
`ifdef BHT_UPDATE_CTRL_STATS_EN
        check("stats_branches_5", bus.o_stat_branches, 5);
        check("stats_mispred_2", bus.o_stat_mispred, 2);
`else
        check("stats_branches_off", bus.o_stat_branches, 0);
        check("stats_mispred_off", bus.o_stat_mispred, 0);
`endif
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
